// File: rtl/zigzag_pkg.sv
// Shared constants and types for the 4x4 inverse zigzag reorder block.
// ZZ2RASTER maps zigzag position k to raster index y*4+x and serves as a reference table.
package zigzag_pkg;

    localparam int BLK_DIM = 4;
    localparam int NCOEFF  = 16;

    typedef enum logic {
        FILL,
        DRAIN
    } state_t;

    localparam logic [3:0] ZZ2RASTER [NCOEFF] = '{
        4'd0,  4'd1,  4'd4,  4'd8,
        4'd5,  4'd2,  4'd3,  4'd6,
        4'd9,  4'd12, 4'd13, 4'd10,
        4'd7,  4'd11, 4'd14, 4'd15
    };

endpackage

// File: rtl/zz_walker.sv
// Generates (x,y) coordinates of a 4x4 zigzag scan, one step per accepted coefficient.
// Diagonals are walked up-right or down-left and the direction flips at the block edges.
module zz_walker
    import zigzag_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       step,
    output logic [1:0] x,
    output logic [1:0] y,
    output logic       done
);

    localparam logic [1:0] EDGE = 2'(BLK_DIM - 1);

    logic       up;
    logic       up_next;
    logic [1:0] x_next;
    logic [1:0] y_next;

    assign done = (x == EDGE) && (y == EDGE);

    // Stepping off the last cell wraps back to the top-left corner for the next block.
    always_comb begin
        x_next  = x;
        y_next  = y;
        up_next = up;
        if (done) begin
            x_next  = 2'd0;
            y_next  = 2'd0;
            up_next = 1'b1;
        end else if (up) begin
            if (x == EDGE) begin
                y_next  = y + 2'd1;
                up_next = 1'b0;
            end else if (y == 2'd0) begin
                x_next  = x + 2'd1;
                up_next = 1'b0;
            end else begin
                x_next = x + 2'd1;
                y_next = y - 2'd1;
            end
        end else begin
            if (y == EDGE) begin
                x_next  = x + 2'd1;
                up_next = 1'b1;
            end else if (x == 2'd0) begin
                y_next  = y + 2'd1;
                up_next = 1'b1;
            end else begin
                x_next = x - 2'd1;
                y_next = y + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            x  <= 2'd0;
            y  <= 2'd0;
            up <= 1'b1;
        end else if (step) begin
            x  <= x_next;
            y  <= y_next;
            up <= up_next;
        end
    end

endmodule

// File: rtl/inverse_zigzag.sv
// Collects 16 coefficients in zigzag order into a register buffer, then streams them out
// in raster order with their index; fill and drain phases never overlap.
module inverse_zigzag
    import zigzag_pkg::*;
#(
    parameter int COEFF_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COEFF_W-1:0] in_coeff,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COEFF_W-1:0] out_coeff,
    output logic [3:0]         out_idx,
    output logic               out_last
);

    state_t             state;
    state_t             state_next;
    logic [COEFF_W-1:0] buffer [NCOEFF];
    logic [1:0]         wx;
    logic [1:0]         wy;
    logic               wdone;
    logic               in_xfer;
    logic               out_xfer;

    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign out_last  = out_valid && (out_idx == 4'hF);
    assign out_coeff = buffer[out_idx];

    zz_walker u_walker (
        .clk  (clk),
        .rst  (rst),
        .clr  (out_xfer && out_last),
        .step (in_xfer),
        .x    (wx),
        .y    (wy),
        .done (wdone)
    );

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid && wdone) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && (out_idx == 4'hF)) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Raster address of the incoming coefficient is simply {y, x} from the walker.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCOEFF; i++) begin
                buffer[i] <= '0;
            end
        end else if (in_xfer) begin
            buffer[{wy, wx}] <= in_coeff;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_idx <= 4'd0;
        end else if (out_xfer) begin
            out_idx <= out_idx + 4'd1;
        end
    end

endmodule

// File: tb/tb_inverse_zigzag.sv
// Self-checking bench for inverse_zigzag: a queue-based reference model derives the expected
// raster stream from the diagonal-scan definition of the zigzag order.
module tb_inverse_zigzag;

    localparam int W = 16;
    localparam int BASIC [16] = '{0, 1, 5, 6, 2, 4, 7, 12, 3, 8, 11, 13, 9, 10, 14, 15};

    typedef struct packed {
        logic [W-1:0] coeff;
        logic [3:0]   idx;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_coeff;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_coeff;
    logic [3:0]   out_idx;
    logic         out_last;

    int           n_cmp = 0;
    int           n_fail = 0;
    int           cycle = 0;
    int           zz_order [16];
    logic [W-1:0] blk_q [$];
    exp_t         exp_q [$];
    logic [W-1:0] obs_q [$];
    int           last_cycles [$];
    bit           draining = 1'b0;

    always #5 clk = ~clk;

    inverse_zigzag #(.COEFF_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_coeff  (in_coeff),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_coeff (out_coeff),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    // Zigzag = anti-diagonals x+y=s; odd diagonals run with x falling, even ones with x rising.
    function automatic void build_zigzag();
        int k;
        int x;
        int y;
        k = 0;
        for (int s = 0; s < 7; s++) begin
            for (int i = 0; i < 4; i++) begin
                x = (s % 2 == 1) ? (s - i) : i;
                y = s - x;
                if (x >= 0 && x < 4 && y >= 0 && y < 4) begin
                    zz_order[k] = y * 4 + x;
                    k++;
                end
            end
        end
    endfunction

    function automatic void model_block_done();
        logic [W-1:0] raster [16];
        exp_t         e;
        for (int k = 0; k < 16; k++) begin
            raster[zz_order[k]] = blk_q[k];
        end
        for (int j = 0; j < 16; j++) begin
            e.coeff = raster[j];
            e.idx   = 4'(j);
            e.last  = (j == 15);
            exp_q.push_back(e);
        end
        blk_q.delete();
        draining = 1'b1;
    endfunction

    // One clock cycle: drive at the falling edge, check handshake and data, then update the model.
    task automatic do_cycle(input logic iv, input logic [W-1:0] ic, input logic ordy);
        exp_t e;
        @(negedge clk);
        in_valid  = iv;
        in_coeff  = ic;
        out_ready = ordy;
        #1;
        cycle++;
        n_cmp++;
        if (in_ready !== !draining || out_valid !== draining) begin
            n_fail++;
            $display("[TB] FAIL handshake cycle %0d: in_ready=%b out_valid=%b, required in_ready=%b out_valid=%b",
                     cycle, in_ready, out_valid, !draining, draining);
        end
        if (draining && exp_q.size() > 0) begin
            e = exp_q[0];
            n_cmp++;
            if ({out_coeff, out_idx, out_last} !== {e.coeff, e.idx, e.last}) begin
                n_fail++;
                $display("[TB] FAIL output cycle %0d: coeff=%h idx=%0d last=%b, required coeff=%h idx=%0d last=%b",
                         cycle, out_coeff, out_idx, out_last, e.coeff, e.idx, e.last);
            end
        end
        if (iv && !draining) begin
            blk_q.push_back(ic);
            if (blk_q.size() == 16) begin
                model_block_done();
            end
        end else if (draining && ordy && exp_q.size() > 0) begin
            obs_q.push_back(out_coeff);
            e = exp_q.pop_front();
            if (e.last) begin
                draining = 1'b0;
                last_cycles.push_back(cycle);
            end
        end
    endtask

    task automatic apply_reset(input logic iv);
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = iv;
        in_coeff  = W'($urandom);
        out_ready = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        blk_q.delete();
        exp_q.delete();
        draining = 1'b0;
    endtask

    task automatic drain_all(input string name);
        for (int i = 0; i < 40 && draining; i++) begin
            do_cycle(1'b0, '0, 1'b1);
        end
        n_cmp++;
        if (draining) begin
            n_fail++;
            $display("[TB] FAIL %s drain timeout: draining=%b, required 0", name, draining);
        end
    endtask

    task automatic test_reset();
        apply_reset(1'b1);
        #1;
        n_cmp += 5;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL reset in_ready: got %b, required 1", in_ready);
        end
        if (out_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset out_valid: got %b, required 0", out_valid);
        end
        if (out_last !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset out_last: got %b, required 0", out_last);
        end
        if (out_idx !== 4'd0) begin
            n_fail++; $display("[TB] FAIL reset out_idx: got %0d, required 0", out_idx);
        end
        if (out_coeff !== '0) begin
            n_fail++; $display("[TB] FAIL reset out_coeff: got %h, required 0", out_coeff);
        end
    endtask

    task automatic test_basic();
        obs_q.delete();
        for (int k = 0; k < 16; k++) begin
            do_cycle(1'b1, W'(k), 1'b1);
        end
        drain_all("basic");
        n_cmp++;
        if (obs_q.size() != 16) begin
            n_fail++; $display("[TB] FAIL basic count: got %0d, required 16", obs_q.size());
        end else begin
            for (int j = 0; j < 16; j++) begin
                n_cmp++;
                if (obs_q[j] !== W'(BASIC[j])) begin
                    n_fail++; $display("[TB] FAIL basic raster %0d: got %0d, required %0d", j, obs_q[j], BASIC[j]);
                end
            end
        end
    endtask

    task automatic test_toggle();
        int  n_xfer;
        logic iv;
        n_xfer = 0;
        obs_q.delete();
        for (int i = 0; i < 36; i++) begin
            iv = (i % 2 == 0);
            do_cycle(iv, W'(n_xfer), 1'b0);
            if (iv && in_ready) n_xfer++;
        end
        n_cmp++;
        if (n_xfer != 16) begin
            n_fail++; $display("[TB] FAIL toggle transfers: got %0d, required 16", n_xfer);
        end
        drain_all("toggle");
        n_cmp++;
        if (obs_q.size() != 16) begin
            n_fail++; $display("[TB] FAIL toggle count: got %0d, required 16", obs_q.size());
        end else begin
            for (int j = 0; j < 16; j++) begin
                n_cmp++;
                if (obs_q[j] !== W'(BASIC[j])) begin
                    n_fail++; $display("[TB] FAIL toggle raster %0d: got %0d, required %0d", j, obs_q[j], BASIC[j]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] data [16];
        logic [W-1:0] held;
        for (int k = 0; k < 16; k++) begin
            data[k] = W'($urandom);
            if (zz_order[k] == 7) held = data[k];
            do_cycle(1'b1, data[k], 1'b1);
        end
        for (int j = 0; j < 7; j++) begin
            do_cycle(1'b0, '0, 1'b1);
        end
        for (int s = 0; s < 5; s++) begin
            do_cycle(1'b1, W'($urandom), 1'b0);
            n_cmp++;
            if (out_coeff !== held || out_idx !== 4'd7 || in_ready !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL stall hold %0d: coeff=%h idx=%0d in_ready=%b, required coeff=%h idx=7 in_ready=0",
                         s, out_coeff, out_idx, in_ready, held);
            end
        end
        drain_all("stall");
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 9; k++) begin
            do_cycle(1'b1, W'($urandom), 1'b1);
        end
        apply_reset(1'b1);
        obs_q.delete();
        for (int k = 0; k < 16; k++) begin
            do_cycle(1'b1, W'(100 + k), 1'b1);
        end
        drain_all("reset_mid");
        n_cmp++;
        if (obs_q.size() != 16) begin
            n_fail++; $display("[TB] FAIL reset_mid count: got %0d, required 16", obs_q.size());
        end else begin
            for (int j = 0; j < 16; j++) begin
                n_cmp++;
                if (obs_q[j] !== W'(100 + BASIC[j])) begin
                    n_fail++; $display("[TB] FAIL reset_mid raster %0d: got %0d, required %0d", j, obs_q[j], 100 + BASIC[j]);
                end
            end
        end
        // A reset in the middle of draining must also clear the buffer and the read index.
        for (int k = 0; k < 16; k++) begin
            do_cycle(1'b1, W'($urandom_range(1, 65535)), 1'b1);
        end
        for (int j = 0; j < 3; j++) begin
            do_cycle(1'b0, '0, 1'b1);
        end
        apply_reset(1'b0);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_idx !== 4'd0 || out_coeff !== '0) begin
            n_fail++;
            $display("[TB] FAIL drain reset: in_ready=%b out_valid=%b idx=%0d coeff=%h, required 1 0 0 0",
                     in_ready, out_valid, out_idx, out_coeff);
        end
    endtask

    task automatic test_back_to_back();
        last_cycles.delete();
        obs_q.delete();
        for (int i = 0; i < 120 && last_cycles.size() < 3; i++) begin
            do_cycle(1'b1, W'($urandom), 1'b1);
        end
        n_cmp++;
        if (last_cycles.size() != 3) begin
            n_fail++; $display("[TB] FAIL b2b blocks: got %0d, required 3", last_cycles.size());
        end else begin
            for (int b = 1; b < 3; b++) begin
                n_cmp++;
                if (last_cycles[b] - last_cycles[b-1] != 32) begin
                    n_fail++;
                    $display("[TB] FAIL b2b spacing %0d: got %0d, required 32", b, last_cycles[b] - last_cycles[b-1]);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 48) begin
            n_fail++; $display("[TB] FAIL b2b outputs: got %0d, required 48", obs_q.size());
        end
    endtask

    task automatic test_extremes();
        obs_q.delete();
        for (int k = 0; k < 16; k++) begin
            if (k == 0) do_cycle(1'b1, 16'h8000, 1'b1);
            else if (k == 15) do_cycle(1'b1, 16'h7FFF, 1'b1);
            else do_cycle(1'b1, W'($urandom), 1'b1);
        end
        drain_all("extremes");
        n_cmp++;
        if (obs_q.size() != 16 || obs_q[0] !== 16'h8000 || obs_q[15] !== 16'h7FFF) begin
            n_fail++;
            $display("[TB] FAIL extremes: count=%0d first=%h last=%h, required 16 8000 7fff",
                     obs_q.size(), obs_q.size() > 0 ? obs_q[0] : '0, obs_q.size() > 15 ? obs_q[15] : '0);
        end
    endtask

    task automatic test_random();
        int start;
        start = last_cycles.size();
        for (int i = 0; i < 600 && last_cycles.size() < start + 3; i++) begin
            do_cycle(1'($urandom), W'($urandom), 1'($urandom));
        end
        n_cmp++;
        if (last_cycles.size() < start + 3) begin
            n_fail++; $display("[TB] FAIL random blocks: got %0d, required 3", last_cycles.size() - start);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_coeff  = '0;
        out_ready = 1'b0;
        build_zigzag();
        test_reset();
        test_basic();
        test_toggle();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_extremes();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/inverse_zigzag.md
INVERSE_ZIGZAG -- requirements
Module: inverse_zigzag

Interface
REQ-001 SHALL have parameter COEFF_W, default 16, giving the coefficient width in bits.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: in_coeff valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepts in_coeff this cycle.
REQ-006 SHALL have port in_coeff, input, COEFF_W bits: coefficient, zigzag order.
REQ-007 SHALL have port out_valid, output, 1 bit: out_coeff valid.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream accepts out_coeff.
REQ-009 SHALL have port out_coeff, output, COEFF_W bits: coefficient, raster order.
REQ-010 SHALL have port out_idx, output, 4 bits: raster index y*4+x of out_coeff.
REQ-011 SHALL have port out_last, output, 1 bit: high with the 16th output coefficient (out_idx=15).

Function
REQ-012 SHALL define transfers: input on in_valid&&in_ready; output on out_valid&&out_ready.
REQ-013 SHALL have states FILL and DRAIN; FILL->DRAIN on the 16th input transfer; DRAIN->FILL on the output transfer with out_last=1.
REQ-014 SHALL drive in_ready=1 only in FILL and out_valid=1 only in DRAIN; the ports are never active together.
REQ-015 SHALL write the k-th input coefficient (k=0..15) of a block into a 16-entry register buffer at position (x,y) from a coordinate walker.
REQ-016 SHALL make the walker produce the 4x4 frame zigzag order: raster 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15.
REQ-017 SHALL generate the walker order by x/y increment/decrement with direction reversal at block edges, not by a lookup ROM; the package table is used for checking only.
REQ-018 SHALL hold the walker position when the input does not transfer; in_valid without in_ready has no effect.
REQ-019 SHALL drive out_coeff=buffer[out_idx] from registers, so out_coeff is valid in the same cycle as out_valid.
REQ-020 SHALL step out_idx 0..15 once per output transfer and hold all output values stable while out_valid=1 and out_ready=0.
REQ-021 SHALL raise out_valid in the cycle after the 16th input transfer, and raise in_ready in the cycle after the last output transfer.
REQ-022 SHALL sustain a throughput of one block per 32 cycles when in_valid=1 and out_ready=1 throughout.
REQ-023 SHALL pass coefficients through bit-exact with no sign or width change; all counters are 4 bits and wrap 15->0 at block end.
REQ-024 SHALL reset the walker to (0,0) and out_idx to 0 at each block start.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, enter FILL with walker (0,0) and out_idx=0.
REQ-026 SHALL hold these values after reset: in_ready=1, out_valid=0, out_last=0, out_idx=0, out_coeff=0, all buffer entries 0.
REQ-027 SHALL treat rst asserted mid-FILL or mid-DRAIN as a discard of the partial block; the next input after reset is zigzag position 0.
REQ-028 SHALL give rst priority over any coincident transfer.

Structure
REQ-029 SHALL place in package zigzag_pkg: BLK_DIM=4, NCOEFF=16, the state enum typedef (FILL, DRAIN) and the ZZ2RASTER constant table.
REQ-030 SHALL implement the x/y zigzag coordinate generator as sub-module zz_walker, with inputs clk, rst, clr, step and outputs x[1:0], y[1:0], done.

Verification
REQ-031 SHALL cover, after reset, inputs 0..15 streamed in zigzag order with out_ready=1: output values in idx order are 0,1,5,6,2,4,7,12,3,8,11,13,9,10,14,15, with out_last at idx 15.
REQ-032 SHALL cover in_valid toggled 1010... during FILL: exactly 16 transfers occur, and the buffer contents match REQ-031.
REQ-033 SHALL cover out_ready held 0 for 5 cycles at idx 7: out_coeff and out_idx stay stable and in_ready stays 0.
REQ-034 SHALL cover rst pulsed after 9 inputs, then a fresh block 100..115: the output raster equals the REQ-031 pattern offset by 100.
REQ-035 SHALL cover three back-to-back blocks: blocks complete at 32-cycle spacing, in_ready and out_valid are never both high, and there is no data loss.
REQ-036 SHALL cover coefficients 0x8000 and 0x7FFF at zigzag positions 0 and 15: they appear unchanged at raster 0 and 15.
